// File: rtl/bitwise_pipe_unit_if.sv
// Request/response bundle for bitwise_pipe_unit.
// Optional flag signals are present only when BITWISE_FLAGS_EN is defined.
interface bitwise_pipe_unit_if #(
    parameter int data_width = 16
);
    logic                  in_valid;
    logic                  in_ready;
    logic [data_width-1:0] A;
    logic [data_width-1:0] B;
    logic [3:0]            FuncCode;
    logic                  chain;
    logic                  out_valid;
    logic                  out_ready;
    logic [data_width-1:0] C;
`ifdef BITWISE_FLAGS_EN
    logic                  out_zero;
    logic                  out_parity;
`endif

    modport master (
        output in_valid, A, B, FuncCode, chain, out_ready,
`ifdef BITWISE_FLAGS_EN
        input  out_zero, out_parity,
`endif
        input  in_ready, out_valid, C
    );

    modport slave (
        input  in_valid, A, B, FuncCode, chain, out_ready,
`ifdef BITWISE_FLAGS_EN
        output out_zero, out_parity,
`endif
        output in_ready, out_valid, C
    );
endinterface

// File: rtl/bitwise_pipe_unit.sv
// Two-stage valid/ready bitwise logic unit with result chaining into operand B.
// Define BITWISE_FLAGS_EN to add registered out_zero/out_parity flags.
module bitwise_pipe_unit #(
    parameter int data_width = 16
) (
    input logic              clk,
    input logic              reset,
    bitwise_pipe_unit_if.slave bus
);
    // Function codes mirror the alu_func.v encodings.
    localparam logic [3:0] FUNC_NOT  = 4'h0;
    localparam logic [3:0] FUNC_AND  = 4'h1;
    localparam logic [3:0] FUNC_OR   = 4'h2;
    localparam logic [3:0] FUNC_NAND = 4'h3;
    localparam logic [3:0] FUNC_NOR  = 4'h4;
    localparam logic [3:0] FUNC_XOR  = 4'h5;

    logic                  s1_valid;
    logic [data_width-1:0] s1_a;
    logic [data_width-1:0] s1_b;
    logic [3:0]            s1_func;
    logic                  s1_chain;
    logic                  out_valid;
    logic [data_width-1:0] c_q;
    logic [data_width-1:0] acc;
    logic [data_width-1:0] bop;
    logic [data_width-1:0] res;
    logic                  adv;
    logic                  in_ready;
    logic                  accept;

    assign adv      = !out_valid || bus.out_ready;
    assign in_ready = !s1_valid || adv;
    assign accept   = bus.in_valid && in_ready;

    always_comb begin
        bop = s1_chain ? acc : s1_b;
        res = '0;
        case (s1_func)
            FUNC_NOT:  res = ~s1_a;
            FUNC_AND:  res = s1_a & bop;
            FUNC_OR:   res = s1_a | bop;
            FUNC_NAND: res = ~(s1_a & bop);
            FUNC_NOR:  res = ~(s1_a | bop);
            FUNC_XOR:  res = s1_a ^ bop;
            default:   res = ~(s1_a ^ bop);
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_func  <= '0;
            s1_chain <= 1'b0;
        end else if (accept) begin
            s1_valid <= 1'b1;
            s1_a     <= bus.A;
            s1_b     <= bus.B;
            s1_func  <= bus.FuncCode;
            s1_chain <= bus.chain;
        end else if (s1_valid && adv) begin
            s1_valid <= 1'b0;
        end
    end

    // acc updates on the transfer edge so a chained op right behind sees it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            c_q       <= '0;
            acc       <= '0;
        end else if (adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                c_q <= res;
                acc <= res;
            end
        end
    end

`ifdef BITWISE_FLAGS_EN
    logic zero_q;
    logic parity_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            zero_q   <= 1'b0;
            parity_q <= 1'b0;
        end else if (adv && s1_valid) begin
            zero_q   <= (res == '0);
            parity_q <= ^res;
        end
    end

    assign bus.out_zero   = zero_q;
    assign bus.out_parity = parity_q;
`endif

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.C         = c_q;
endmodule

// File: tb/tb_bitwise_pipe_unit.sv
// Self-checking bench for bitwise_pipe_unit: directed scenarios plus random traffic
// against an in-flight queue model (flags checked when BITWISE_FLAGS_EN is defined).
module tb_bitwise_pipe_unit;
    localparam int W = 16;
    localparam logic [3:0] F_NOT  = 4'h0;
    localparam logic [3:0] F_AND  = 4'h1;
    localparam logic [3:0] F_OR   = 4'h2;
    localparam logic [3:0] F_NAND = 4'h3;
    localparam logic [3:0] F_NOR  = 4'h4;
    localparam logic [3:0] F_XOR  = 4'h5;

    typedef struct {
        logic [W-1:0] c;
        int unsigned  acc_edge;
    } item_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    bitwise_pipe_unit_if #(.data_width(W)) bus ();
    bitwise_pipe_unit #(.data_width(W)) dut (.clk(clk), .reset(reset), .bus(bus));

    item_t        q[$];
    logic [W-1:0] got[$];
    logic [W-1:0] m_acc;
    int unsigned  edges;
    int           checks;
    int           errors;
    int           accepts;
    bit           last_accept;

    function automatic logic [W-1:0] ref_op(logic [3:0] f, logic [W-1:0] a, logic [W-1:0] b);
        case (f)
            F_NOT:   return ~a;
            F_AND:   return a & b;
            F_OR:    return a | b;
            F_NAND:  return ~(a & b);
            F_NOR:   return ~(a | b);
            F_XOR:   return a ^ b;
            default: return ~(a ^ b);
        endcase
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(bit v, logic [W-1:0] a, logic [W-1:0] b, logic [3:0] f, bit ch, bit ordy);
        bus.in_valid  = v;
        bus.A         = a;
        bus.B         = b;
        bus.FuncCode  = f;
        bus.chain     = ch;
        bus.out_ready = ordy;
    endtask

    // One clock: check at negedge, then advance the model on the posedge.
    task automatic cycle();
        bit           acc_now;
        bit           pop_now;
        logic [3:0]   f;
        logic [W-1:0] a;
        logic [W-1:0] b;
        bit           ch;
        logic [W-1:0] r;
        @(negedge clk);
        chk("in_ready", 32'(bus.in_ready), 32'(!(q.size() == 2 && !bus.out_ready)));
        chk("out_valid", 32'(bus.out_valid), 32'(q.size() > 0 && edges > q[0].acc_edge));
        acc_now = bus.in_valid && bus.in_ready;
        pop_now = bus.out_valid && bus.out_ready;
        f = bus.FuncCode; a = bus.A; b = bus.B; ch = bus.chain;
        if (pop_now) begin
            if (q.size() == 0) begin
                chk("spurious_output", 32'(bus.C), 32'hDEAD_BEEF);
            end else begin
                chk("C", 32'(bus.C), 32'(q[0].c));
`ifdef BITWISE_FLAGS_EN
                chk("out_zero", 32'(bus.out_zero), 32'(q[0].c == '0));
                chk("out_parity", 32'(bus.out_parity), 32'(^q[0].c));
`endif
            end
            got.push_back(bus.C);
        end
        @(posedge clk);
        edges++;
        if (pop_now && q.size() > 0) void'(q.pop_front());
        if (acc_now) begin
            r = ref_op(f, a, ch ? m_acc : b);
            m_acc = r;
            q.push_back('{c: r, acc_edge: edges});
            accepts++;
        end
        last_accept = acc_now;
        #1;
    endtask

    task automatic drain(string tag);
        int n;
        n = 0;
        drive(1'b0, '0, '0, F_AND, 1'b0, 1'b1);
        while (q.size() > 0 && n < 10) begin
            cycle();
            n++;
        end
        chk(tag, 32'(q.size()), 32'd0);
    endtask

    task automatic issue(logic [W-1:0] a, logic [W-1:0] b, logic [3:0] f, bit ch);
        drive(1'b1, a, b, f, ch, 1'b1);
        cycle();
    endtask

    initial begin
        logic [W-1:0] exp4[4];
        int idx;
        checks = 0; errors = 0; edges = 0; accepts = 0; m_acc = '0;
        drive(1'b0, '0, '0, F_AND, 1'b0, 1'b1);
        reset = 1'b1;
        #3;
        chk("reset_in_ready", 32'(bus.in_ready), 32'd1);
        chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
        chk("reset_C", 32'(bus.C), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Basic ops back to back
        got.delete();
        issue(16'h00FF, 16'h0F0F, F_AND, 1'b0);
        issue(16'h00FF, 16'h0F0F, F_OR,  1'b0);
        issue(16'h00FF, 16'h0F0F, F_XOR, 1'b0);
        issue(16'h00FF, 16'h0F0F, F_NOR, 1'b0);
        drain("basic_drain");
        exp4 = '{16'h000F, 16'h0FFF, 16'h0FF0, 16'hF000};
        chk("basic_count", 32'(got.size()), 32'd4);
        for (int i = 0; i < 4 && i < got.size(); i++) chk("basic_value", 32'(got[i]), 32'(exp4[i]));

        // Undefined code falls back to XNOR
        got.delete();
        issue(16'hAAAA, 16'hFFFF, 4'hF, 1'b0);
        drain("fallback_drain");
        if (got.size() > 0) chk("fallback_value", 32'(got[0]), 32'hAAAA);
        else chk("fallback_count", 32'd0, 32'd1);

        // Chaining, back to back
        got.delete();
        issue(16'hF0F0, 16'hFF00, F_AND, 1'b0);
        issue(16'h000F, 16'h1234, F_OR,  1'b1);
        issue(16'hFFFF, 16'h5678, F_XOR, 1'b1);
        drain("chain_drain");
        exp4 = '{16'hF000, 16'hF00F, 16'h0FF0, 16'h0000};
        chk("chain_count", 32'(got.size()), 32'd3);
        for (int i = 0; i < 3 && i < got.size(); i++) chk("chain_value", 32'(got[i]), 32'(exp4[i]));

        // Backpressure: 4 ops, consumer stalled for 5 cycles
        got.delete();
        accepts = 0;
        idx = 0;
        for (int cyc = 0; cyc < 40 && (idx < 4 || q.size() > 0); cyc++) begin
            if (idx < 4) drive(1'b1, W'($urandom), W'($urandom), 4'($urandom_range(0, 7)), 1'b0, cyc >= 5);
            else drive(1'b0, '0, '0, F_AND, 1'b0, 1'b1);
            cycle();
            if (last_accept) idx++;
            if (cyc == 4) chk("bp_accepts_while_stalled", 32'(accepts), 32'd2);
        end
        chk("bp_all_accepted", 32'(accepts), 32'd4);
        chk("bp_all_delivered", 32'(got.size()), 32'd4);

`ifdef BITWISE_FLAGS_EN
        got.delete();
        issue(16'h1234, 16'h1234, F_XOR, 1'b0);
        issue(16'h0007, 16'hFFFF, F_AND, 1'b0);
        drain("flags_drain");
        chk("flags_count", 32'(got.size()), 32'd2);
`endif

        // Random traffic with random backpressure and chaining
        for (int i = 0; i < 300; i++) begin
            drive(1'($urandom), W'($urandom), W'($urandom), 4'($urandom), 1'($urandom), $urandom_range(0, 3) != 0);
            cycle();
        end
        drain("random_drain");

        // Reset mid-stream discards in-flight ops and clears acc
        drive(1'b1, 16'h1111, 16'h2222, F_OR, 1'b0, 1'b0);
        cycle();
        cycle();
        #2;
        reset = 1'b1;
        #1;
        chk("midreset_out_valid", 32'(bus.out_valid), 32'd0);
        chk("midreset_C", 32'(bus.C), 32'd0);
        chk("midreset_in_ready", 32'(bus.in_ready), 32'd1);
        q.delete();
        m_acc = '0;
        drive(1'b0, '0, '0, F_AND, 1'b0, 1'b1);
        @(posedge clk); #1;
        reset = 1'b0;
        got.delete();
        issue(16'h0000, 16'hFFFF, F_OR, 1'b1);
        drain("post_reset_drain");
        chk("post_reset_count", 32'(got.size()), 32'd1);
        if (got.size() > 0) chk("chain_after_reset", 32'(got[0]), 32'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
